// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Eight-source prioritised interrupt controller with a
//               rising-edge request register (IRR), an in-service register
//               (ISR), a programmable mask (IMR) and an INTA/EOI handshake.
//               Bit 7 is the highest priority and bit 0 the lowest.
// Config      : define INT_NEST_EN to let a higher-priority source interrupt
//               one already in service. Without it, a new request is only
//               raised when nothing is in service.
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
  parameter logic [7:0] RESET_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       inta,
  input  logic       eoi,
  output logic       intr,
  output logic [2:0] vec,
  output logic       valid,
  output logic       spur,
  output logic [7:0] imr
);

  // Vector returned when an acknowledge finds nothing left to service.
  localparam logic [2:0] C_SPUR_VEC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_irq_q;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  logic [7:0] r_imr;
  logic       r_intr;
  logic [2:0] r_vec;
  logic       r_valid;
  logic       r_spur;

  logic [7:0] w_edge;
  logic [7:0] w_pending;
  logic       w_pend_any;
  logic [2:0] w_top;
  logic       w_isr_any;
  logic [2:0] w_isr_top;
  logic       w_qualify;

  logic       w_ack;
  logic       w_spur_ack;
  logic [7:0] w_ack_bit;
  logic [7:0] w_eoi_clr;
  logic [7:0] w_irr_nxt;
  logic [7:0] w_isr_nxt;
  logic [2:0] w_vec_nxt;
  logic       w_valid_nxt;
  logic       w_spur_nxt;
  logic       w_intr_nxt;

  // Index of the highest set bit; the scan runs upward so the top bit wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = i[2:0];
      end
    end
    return idx;
  endfunction

  // One-hot decode of a source number.
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // A request is a 0->1 transition against the previous sample.
  assign w_edge     = irq & ~r_irq_q;

  assign w_pending  = r_irr & ~r_imr;
  assign w_pend_any = |w_pending;
  assign w_top      = prio_enc(w_pending);

  assign w_isr_any  = |r_isr;
  assign w_isr_top  = prio_enc(r_isr);

`ifdef INT_NEST_EN
  // Nesting: the best pending source must outrank everything in service.
  assign w_qualify  = w_pend_any && (!w_isr_any || (w_top > w_isr_top));
`else
  // No nesting: a new request waits until the ISR is fully cleared.
  assign w_qualify  = w_pend_any && !w_isr_any;
`endif

  // Next-state decode for the request/acknowledge handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_spur_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_qualify) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (inta) begin
          w_state_nxt = ST_ACK;
          if (w_qualify) begin
            w_ack = 1'b1;
          end else begin
            w_spur_ack = 1'b1;
          end
        end else if (!w_qualify) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register updates implied by this cycle's acknowledge, EOI and new edges.
  always_comb begin
    w_ack_bit   = 8'h00;
    w_eoi_clr   = 8'h00;
    w_vec_nxt   = r_vec;
    if (w_ack) begin
      w_ack_bit = onehot(w_top);
      w_vec_nxt = w_top;
    end else if (w_spur_ack) begin
      w_vec_nxt = C_SPUR_VEC;
    end
    // EOI retires the highest bit of the ISR as it stood before this edge,
    // so an acknowledge landing in the same cycle is not undone.
    if (eoi && w_isr_any) begin
      w_eoi_clr = onehot(w_isr_top);
    end
    // A fresh edge on the acknowledged line re-arms it.
    w_irr_nxt   = (r_irr & ~w_ack_bit) | w_edge;
    w_isr_nxt   = (r_isr & ~w_eoi_clr) | w_ack_bit;
    w_valid_nxt = w_ack | w_spur_ack;
    w_spur_nxt  = w_spur_ack;
    w_intr_nxt  = (w_state_nxt == ST_REQ);
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Edge-detect sample; it tracks irq during reset so lines already high
  // at release are not seen as new requests.
  always_ff @(posedge clk) begin
    r_irq_q <= irq;
  end

  // Request, service and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irr <= 8'h00;
      r_isr <= 8'h00;
      r_imr <= RESET_MASK;
    end else begin
      r_irr <= w_irr_nxt;
      r_isr <= w_isr_nxt;
      if (we) begin
        r_imr <= wdata;
      end
    end
  end

  // Registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_intr  <= 1'b0;
      r_vec   <= 3'd0;
      r_valid <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      r_intr  <= w_intr_nxt;
      r_vec   <= w_vec_nxt;
      r_valid <= w_valid_nxt;
      r_spur  <= w_spur_nxt;
    end
  end

  assign intr  = r_intr;
  assign vec   = r_vec;
  assign valid = r_valid;
  assign spur  = r_spur;
  assign imr   = r_imr;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Self-checking bench for int_ctrl. A behavioural model tracks
//               the request/service/mask sets and the handshake phase; a
//               compare process checks the DUT against it every cycle, and
//               directed scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

  localparam logic [7:0] RESET_MASK = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic       we;
  logic [7:0] wdata;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [2:0] vec;
  logic       valid;
  logic       spur;
  logic [7:0] imr;

  int n_tests = 0;
  int n_fail  = 0;

  int_ctrl #(.RESET_MASK(RESET_MASK)) dut (
    .clk   (clk),
    .rst   (rst),
    .irq   (irq),
    .we    (we),
    .wdata (wdata),
    .inta  (inta),
    .eoi   (eoi),
    .intr  (intr),
    .vec   (vec),
    .valid (valid),
    .spur  (spur),
    .imr   (imr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting, 1 = request raised to CPU, 2 = vector presented
  logic [7:0] m_irr, m_isr, m_imr, m_prev;
  int         m_phase;
  logic       m_intr, m_valid, m_spur;
  logic [2:0] m_vec;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit qualifies(input logic [7:0] irr_v, input logic [7:0] imr_v,
                                   input logic [7:0] isr_v);
    int t;
    t = highest(irr_v & ~imr_v);
    if (t < 0) return 1'b0;
`ifdef INT_NEST_EN
    return highest(isr_v) < t;
`else
    return isr_v == 8'h00;
`endif
  endfunction

  task automatic model_step();
    bit         q;
    int         t;
    int         h;
    logic [7:0] n_irr;
    logic [7:0] n_isr;
    if (rst) begin
      m_irr = 8'h00; m_isr = 8'h00; m_imr = RESET_MASK; m_phase = 0;
      m_intr = 1'b0; m_valid = 1'b0; m_spur = 1'b0; m_vec = 3'd0;
      m_prev = irq;
      return;
    end
    q     = qualifies(m_irr, m_imr, m_isr);
    t     = highest(m_irr & ~m_imr);
    n_irr = m_irr;
    n_isr = m_isr;
    h     = highest(m_isr);
    if (eoi && h >= 0) n_isr[h] = 1'b0;
    m_valid = 1'b0;
    m_spur  = 1'b0;
    case (m_phase)
      0: if (q) m_phase = 1;
      1: begin
        if (inta) begin
          if (q) begin
            m_vec = 3'(t);
            n_irr[t] = 1'b0;
            n_isr[t] = 1'b1;
          end else begin
            m_vec  = 3'd7;
            m_spur = 1'b1;
          end
          m_valid = 1'b1;
          m_phase = 2;
        end else if (!q) begin
          m_phase = 0;
        end
      end
      default: m_phase = 0;
    endcase
    m_irr  = n_irr | (irq & ~m_prev);
    m_isr  = n_isr;
    m_prev = irq;
    if (we) m_imr = wdata;
    m_intr = (m_phase == 1);
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every observable against the model.
  always @(negedge clk) begin
    chk("m_intr",  {31'd0, intr},  {31'd0, m_intr});
    chk("m_vec",   {29'd0, vec},   {29'd0, m_vec});
    chk("m_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("m_spur",  {31'd0, spur},  {31'd0, m_spur});
    chk("m_imr",   {24'd0, imr},   {24'd0, m_imr});
    chk("m_isr",   {24'd0, dut.r_isr}, {24'd0, m_isr});
    chk("m_irr",   {24'd0, dut.r_irr}, {24'd0, m_irr});
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_intr(input string name);
    int n = 0;
    while (!intr && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_intr_wait"}, {31'd0, intr}, 32'd1);
  endtask

  task automatic ack_expect(input logic [2:0] ev, input bit do_eoi, input string name);
    wait_intr(name);
    inta = 1'b1; tick(); inta = 1'b0;
    chk({name, "_valid"}, {31'd0, valid}, 32'd1);
    chk({name, "_vec"},   {29'd0, vec},   {29'd0, ev});
    chk({name, "_spur"},  {31'd0, spur},  32'd0);
    if (do_eoi) begin
      eoi = 1'b1; tick(); eoi = 1'b0;
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    we = 1'b1; wdata = m; tick(); we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = 8'h00; we = 1'b0; wdata = 8'h00; inta = 1'b0; eoi = 1'b0;
    tick(2);
    chk("rst_intr",  {31'd0, intr},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_vec",   {29'd0, vec},   32'd0);
    chk("rst_imr",   {24'd0, imr},   32'hFF);
    rst = 1'b0;

    // Single source, basic handshake.
    write_mask(8'h00);
    chk("s1_imr", {24'd0, imr}, 32'h00);
    irq = 8'h08; tick();
    chk("s1_intr_lat1", {31'd0, intr}, 32'd0);
    tick();
    chk("s1_intr_lat2", {31'd0, intr}, 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s1_valid", {31'd0, valid}, 32'd1);
    chk("s1_vec",   {29'd0, vec},   32'd3);
    chk("s1_intr_low", {31'd0, intr}, 32'd0);
    chk("s1_isr",   {24'd0, dut.r_isr}, 32'h08);
    chk("s1_irr",   {24'd0, dut.r_irr}, 32'h00);
    tick();
    chk("s1_valid_once", {31'd0, valid}, 32'd0);
    chk("s1_vec_hold",   {29'd0, vec},   32'd3);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("s1_isr_eoi", {24'd0, dut.r_isr}, 32'h00);

    // Three simultaneous sources served in priority order.
    irq = 8'h00; tick();
    irq = 8'hB0; tick();
    ack_expect(3'd7, 1'b1, "s2_a");
    ack_expect(3'd5, 1'b1, "s2_b");
    ack_expect(3'd4, 1'b1, "s2_c");
    chk("s2_isr_done", {24'd0, dut.r_isr}, 32'h00);

    // Higher-priority request while source 3 is in service.
    irq = 8'h00; tick();
    irq = 8'h08; tick();
    ack_expect(3'd3, 1'b0, "s3_first");
    chk("s3_isr", {24'd0, dut.r_isr}, 32'h08);
    irq = 8'h48; tick();
`ifdef INT_NEST_EN
    ack_expect(3'd6, 1'b1, "s3_nest");
    eoi = 1'b1; tick(); eoi = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_no_nest_intr", {31'd0, intr}, 32'd0);
    end
    eoi = 1'b1; tick(); eoi = 1'b0;
    ack_expect(3'd6, 1'b1, "s3_after_eoi");
`endif
    chk("s3_isr_done", {24'd0, dut.r_isr}, 32'h00);

    // Mask the requesting source under a raised INTR -> spurious acknowledge.
    irq = 8'h00; tick();
    irq = 8'h04; tick();
    wait_intr("s4");
    write_mask(8'h04);
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s4_valid", {31'd0, valid}, 32'd1);
    chk("s4_vec",   {29'd0, vec},   32'd7);
    chk("s4_spur",  {31'd0, spur},  32'd1);
    chk("s4_intr",  {31'd0, intr},  32'd0);
    chk("s4_isr",   {24'd0, dut.r_isr}, 32'h00);
    tick();
    chk("s4_spur_clr", {31'd0, spur}, 32'd0);
    write_mask(8'h00);
    ack_expect(3'd2, 1'b1, "s4_unmask");

    // Lines high through reset release raise nothing until a real edge.
    irq = 8'hFF; rst = 1'b1; tick(2); rst = 1'b0;
    write_mask(8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_no_intr", {31'd0, intr}, 32'd0);
    end
    chk("s5_irr", {24'd0, dut.r_irr}, 32'h00);
    irq = 8'hFE; tick();
    irq = 8'hFF; tick();
    ack_expect(3'd0, 1'b1, "s5_bit0");

    // Reset in the ACK cycle.
    irq = 8'h00; tick();
    irq = 8'h02; tick();
    wait_intr("s6");
    inta = 1'b1; tick(); inta = 1'b0;
    chk("s6_valid_pre", {31'd0, valid}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_valid", {31'd0, valid}, 32'd0);
    chk("s6_isr",   {24'd0, dut.r_isr}, 32'h00);
    chk("s6_imr",   {24'd0, imr}, {24'd0, RESET_MASK});

    // Reset together with INTA in REQ aborts the acknowledge.
    irq = 8'h00; write_mask(8'h00);
    irq = 8'h20; tick();
    wait_intr("s7");
    inta = 1'b1; rst = 1'b1; tick(); inta = 1'b0; rst = 1'b0;
    chk("s7_valid", {31'd0, valid}, 32'd0);
    chk("s7_isr",   {24'd0, dut.r_isr}, 32'h00);
    chk("s7_intr",  {31'd0, intr},  32'd0);
    write_mask(8'h00);

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      irq   = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      we    = ($urandom_range(0, 24) == 0);
      wdata = 8'($urandom) & 8'($urandom);
      inta  = intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eoi   = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0; inta = 1'b0; eoi = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
